writeback_unit: RTL and testbench

- Write-side front end of the register file, sitting in the WB stage.
- Merges single-cycle ALU results with variable-latency load returns.
- Buffers loads in a small FIFO and sign- or zero-extends load data by funct3.
- Drives the register file's regWrite / rd_addr / write_data from registers, and exposes a pending-load check for the hazard unit.

---
 rtl/writeback_unit.sv | 187 ++++++++++++++++++
 tb/tb_writeback_unit.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: register-file write front end in the WB stage.
// ALU results have priority and are written one cycle after they arrive.
// Load returns are extended on entry and queued in a small FIFO. The FIFO
// drains whenever the ALU is idle. A starvation counter asks upstream for
// a one-cycle ALU hold when buffered loads keep losing arbitration.
module writeback_unit #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [4:0]       mem_rd,
  input  logic [WIDTH-1:0] mem_data,
  input  logic [2:0]       mem_funct3,
  input  logic [1:0]       mem_addr_lo,
  output logic             alu_stall,
  input  logic [4:0]       chk_addr,
  output logic             chk_pending,
  output logic             regWrite,
  output logic [4:0]       rd_addr,
  output logic [WIDTH-1:0] write_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] STV_LAST = STV_W'(STARVE_LIMIT - 1);

  // Load-type encodings (funct3); anything not listed behaves as LW.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Selects the addressed byte/halfword lane and extends it to WIDTH.
  // The halfword lane ignores addr_lo[0].
  function automatic logic [WIDTH-1:0] f_extract(
    input logic [WIDTH-1:0] data,
    input logic [2:0]       f3,
    input logic [1:0]       lo
  );
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [WIDTH-1:0] res;
    case (lo)
      2'd0:    lane_b = data[7:0];
      2'd1:    lane_b = data[15:8];
      2'd2:    lane_b = data[23:16];
      default: lane_b = data[31:24];
    endcase
    lane_h = lo[1] ? data[31:16] : data[15:0];
    case (f3)
      F3_LB:   res = {{(WIDTH-8){lane_b[7]}}, lane_b};
      F3_LBU:  res = {{(WIDTH-8){1'b0}}, lane_b};
      F3_LH:   res = {{(WIDTH-16){lane_h[15]}}, lane_h};
      F3_LHU:  res = {{(WIDTH-16){1'b0}}, lane_h};
      default: res = data;
    endcase
    return res;
  endfunction

  // FIFO storage (data only, not reset) and control state.
  logic [4:0]       r_rd_q   [DEPTH];
  logic [WIDTH-1:0] r_data_q [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [STV_W-1:0] r_starve;
  logic             r_alu_stall;

  // Registered write port toward the register file.
  logic             r_reg_write;
  logic [4:0]       r_rd_addr;
  logic [WIDTH-1:0] r_write_data;

  logic             w_ready;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_lose;
  logic [WIDTH-1:0] w_ext;
  logic [4:0]       w_head_rd;
  logic [WIDTH-1:0] w_head_data;
  logic             w_pending;

  // A full FIFO refuses pushes even if it pops this cycle; the refill
  // bubble is accepted to keep mem_ready a pure function of the count.
  assign w_ready     = (r_count != FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_push      = mem_valid && w_ready;
  assign w_pop       = !alu_valid && !w_empty;
  assign w_lose      = alu_valid && !w_empty;
  assign w_ext       = f_extract(mem_data, mem_funct3, mem_addr_lo);
  assign w_head_rd   = r_rd_q[r_rd_ptr];
  assign w_head_data = r_data_q[r_rd_ptr];

  // Scan occupied FIFO slots for a pending write to the queried register.
  always_comb begin
    logic [PTR_W-1:0] w_off;
    w_pending = 1'b0;
    w_off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PTR_W'(i) - r_rd_ptr;
      if ((CNT_W'(w_off) < r_count) && (r_rd_q[i] == chk_addr)) begin
        w_pending = 1'b1;
      end
    end
  end

  // Capture the extracted load into the tail slot.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_q[r_wr_ptr]   <= mem_rd;
      r_data_q[r_wr_ptr] <= w_ext;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Count consecutive lost arbitrations; on the limit, pulse alu_stall once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve    <= '0;
      r_alu_stall <= 1'b0;
    end else begin
      r_alu_stall <= 1'b0;
      if (!w_lose) begin
        r_starve <= '0;
      end else if (r_starve == STV_LAST) begin
        r_starve    <= '0;
        r_alu_stall <= 1'b1;
      end else begin
        r_starve <= r_starve + STV_W'(1);
      end
    end
  end

  // Register the arbitration winner; rd=0 winners are consumed silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_write  <= 1'b0;
      r_rd_addr    <= '0;
      r_write_data <= '0;
    end else if (alu_valid) begin
      r_reg_write  <= (alu_rd != 5'd0);
      r_rd_addr    <= alu_rd;
      r_write_data <= alu_result;
    end else if (w_pop) begin
      r_reg_write  <= (w_head_rd != 5'd0);
      r_rd_addr    <= w_head_rd;
      r_write_data <= w_head_data;
    end else begin
      r_reg_write  <= 1'b0;
    end
  end

  assign mem_ready   = w_ready;
  assign chk_pending = w_pending && (chk_addr != 5'd0);
  assign alu_stall   = r_alu_stall;
  assign regWrite    = r_reg_write;
  assign rd_addr     = r_rd_addr;
  assign write_data  = r_write_data;

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: scoreboard bench for writeback_unit. A behavioural
// model predicts the registered outputs of every clock edge; predictions are
// queued as stimulus is applied and popped after the edge for comparison.
module tb_writeback_unit;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic             clk;
  logic             rst;
  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [WIDTH-1:0] alu_result;
  logic             mem_valid;
  logic             mem_ready;
  logic [4:0]       mem_rd;
  logic [WIDTH-1:0] mem_data;
  logic [2:0]       mem_funct3;
  logic [1:0]       mem_addr_lo;
  logic             alu_stall;
  logic [4:0]       chk_addr;
  logic             chk_pending;
  logic             regWrite;
  logic [4:0]       rd_addr;
  logic [WIDTH-1:0] write_data;

  writeback_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
    .alu_stall(alu_stall), .chk_addr(chk_addr), .chk_pending(chk_pending),
    .regWrite(regWrite), .rd_addr(rd_addr), .write_data(write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        stall;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_t;

  exp_t        sbq[$];
  ld_t         mq[$];
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          m_starve;
  int          n_total;
  int          n_bad;

  function automatic logic [31:0] ref_ext(input logic [31:0] d, input logic [2:0] f3,
                                          input logic [1:0] lo);
    logic [31:0] sb, sh;
    logic [7:0]  b;
    logic [15:0] hw;
    sb = d >> (8 * lo);
    sh = d >> (16 * lo[1]);
    b  = sb[7:0];
    hw = sh[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{hw[15]}}, hw};
      3'b101:  return {16'h0, hw};
      default: return d;
    endcase
  endfunction

  function automatic logic ref_pending(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    sbq.delete();
    m_rd = '0;
    m_data = '0;
    m_starve = 0;
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    mem_funct3 = 3'b010; mem_addr_lo = 2'd0;
  endtask

  // Predict the edge outcome of the currently driven inputs, queue it, clock.
  task automatic step();
    exp_t e;
    ld_t  h;
    logic do_push;
    do_push = mem_valid && (mq.size() < DEPTH);
    e.stall = 1'b0;
    if (mq.size() != 0 && alu_valid) begin
      m_starve++;
      if (m_starve == LIMIT) begin
        m_starve = 0;
        e.stall = 1'b1;
      end
    end else begin
      m_starve = 0;
    end
    if (alu_valid) begin
      e.we = (alu_rd != 5'd0); m_rd = alu_rd; m_data = alu_result;
    end else if (mq.size() != 0) begin
      h = mq.pop_front();
      e.we = (h.rd != 5'd0); m_rd = h.rd; m_data = h.data;
    end else begin
      e.we = 1'b0;
    end
    if (do_push) begin
      h.rd = mem_rd;
      h.data = ref_ext(mem_data, mem_funct3, mem_addr_lo);
      mq.push_back(h);
    end
    e.rd = m_rd;
    e.data = m_data;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    chk_addr = 5'd5;
    rst = 1'b0;
    model_reset();
    #12;
    n_total++;
    if ({regWrite, rd_addr, write_data, alu_stall} !== 39'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got we=%0b rd=%0d data=%h stall=%0b required all zero",
               regWrite, rd_addr, write_data, alu_stall);
    end
    n_total++;
    if (mem_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready got %0b required 1", mem_ready);
    end
    n_total++;
    if (chk_pending !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pending got %0b required 0", chk_pending);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_single();
    exp_t e;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'hDEADBEEF;
    step();
    e = sbq.pop_front();
    n_total++;
    if ({regWrite, rd_addr, write_data} !== {1'b1, 5'd5, 32'hDEADBEEF} ||
        {regWrite, rd_addr, write_data} !== {e.we, e.rd, e.data}) begin
      n_bad++;
      $display("FAIL alu_single got we=%0b rd=%0d data=%h required we=1 rd=5 data=deadbeef",
               regWrite, rd_addr, write_data);
    end
    drive_idle();
    step();
    e = sbq.pop_front();
    n_total++;
    if ({regWrite, rd_addr, write_data} !== {e.we, e.rd, e.data} || regWrite !== 1'b0) begin
      n_bad++;
      $display("FAIL alu_idle_hold got we=%0b rd=%0d data=%h required we=0 rd=%0d data=%h",
               regWrite, rd_addr, write_data, e.rd, e.data);
    end
  endtask

  task automatic test_load_extract();
    logic [2:0]  f3s  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
    logic [31:0] exps [6] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF,
                              32'h000080FF, 32'h80FF7F01, 32'h80FF7F01};
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      drive_idle();
      mem_valid = 1'b1; mem_rd = 5'(9 + k); mem_data = 32'h80FF7F01;
      mem_funct3 = f3s[k]; mem_addr_lo = 2'd2;
      step();
      e = sbq.pop_front();
      n_total++;
      if (regWrite !== 1'b0) begin
        n_bad++;
        $display("FAIL load_nobypass f3=%0d got we=%0b required 0", f3s[k], regWrite);
      end
      drive_idle();
      step();
      e = sbq.pop_front();
      n_total++;
      if ({regWrite, rd_addr, write_data} !== {1'b1, 5'(9 + k), exps[k]} ||
          {regWrite, rd_addr, write_data} !== {e.we, e.rd, e.data}) begin
        n_bad++;
        $display("FAIL load_extract f3=%0d got we=%0b rd=%0d data=%h required we=1 rd=%0d data=%h",
                 f3s[k], regWrite, rd_addr, write_data, 9 + k, exps[k]);
      end
    end
  endtask

  task automatic test_alu_and_load();
    exp_t e;
    drive_idle();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 32'h00000033;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h12345678; mem_funct3 = 3'b010;
    step();
    e = sbq.pop_front();
    n_total++;
    if ({regWrite, rd_addr, write_data} !== {1'b1, 5'd3, 32'h33} ||
        {regWrite, rd_addr, write_data} !== {e.we, e.rd, e.data}) begin
      n_bad++;
      $display("FAIL race_alu_first got we=%0b rd=%0d data=%h required we=1 rd=3 data=33",
               regWrite, rd_addr, write_data);
    end
    drive_idle();
    chk_addr = 5'd4;
    #1;
    n_total++;
    if (chk_pending !== 1'b1) begin
      n_bad++;
      $display("FAIL pending_x4 got %0b required 1", chk_pending);
    end
    chk_addr = 5'd3;
    #1;
    n_total++;
    if (chk_pending !== 1'b0) begin
      n_bad++;
      $display("FAIL pending_x3 got %0b required 0", chk_pending);
    end
    step();
    e = sbq.pop_front();
    n_total++;
    if ({regWrite, rd_addr, write_data} !== {1'b1, 5'd4, 32'h12345678} ||
        {regWrite, rd_addr, write_data} !== {e.we, e.rd, e.data}) begin
      n_bad++;
      $display("FAIL race_load_second got we=%0b rd=%0d data=%h required we=1 rd=4 data=12345678",
               regWrite, rd_addr, write_data);
    end
    chk_addr = 5'd4;
    #1;
    n_total++;
    if (chk_pending !== 1'b0) begin
      n_bad++;
      $display("FAIL pending_cleared got %0b required 0", chk_pending);
    end
  endtask

  task automatic test_starve();
    exp_t e;
    int   first_stall;
    bit   seen;
    first_stall = -1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      drive_idle();
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_result = $urandom;
      if (i < 2) begin
        mem_valid = 1'b1; mem_rd = 5'(20 + i); mem_data = 32'hA0000000 | i; mem_funct3 = 3'b010;
      end
      step();
      e = sbq.pop_front();
      n_total++;
      if ({regWrite, rd_addr, write_data, alu_stall} !== {e.we, e.rd, e.data, e.stall}) begin
        n_bad++;
        $display("FAIL starve_cycle%0d got we=%0b rd=%0d data=%h stall=%0b required we=%0b rd=%0d data=%h stall=%0b",
                 i, regWrite, rd_addr, write_data, alu_stall, e.we, e.rd, e.data, e.stall);
      end
      if (i == 1) begin
        n_total++;
        if (mem_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL full_ready got %0b required 0", mem_ready);
        end
      end
      if (alu_stall === 1'b1 && first_stall < 0) first_stall = i;
      if (e.stall) seen = 1'b1;
    end
    n_total++;
    if (first_stall != 4) begin
      n_bad++;
      $display("FAIL stall_timing got cycle %0d required cycle 4", first_stall);
    end
    drive_idle();
    step();
    e = sbq.pop_front();
    n_total++;
    if ({regWrite, rd_addr, write_data, alu_stall} !== {1'b1, 5'd20, 32'hA0000000, 1'b0} ||
        {regWrite, rd_addr, write_data} !== {e.we, e.rd, e.data}) begin
      n_bad++;
      $display("FAIL stall_drain got we=%0b rd=%0d data=%h stall=%0b required we=1 rd=20 data=a0000000 stall=0",
               regWrite, rd_addr, write_data, alu_stall);
    end
    step();
    e = sbq.pop_front();
    n_total++;
    if ({regWrite, rd_addr, write_data} !== {1'b1, 5'd21, 32'hA0000001} || mem_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_second got we=%0b rd=%0d data=%h ready=%0b required we=1 rd=21 data=a0000001 ready=1",
               regWrite, rd_addr, write_data, mem_ready);
    end
  endtask

  task automatic test_rd_zero();
    exp_t e;
    drive_idle();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 32'h0000AAAA;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h5555; mem_funct3 = 3'b010;
    for (int i = 0; i < 3; i++) begin
      step();
      e = sbq.pop_front();
      n_total++;
      if (regWrite !== 1'b0 || {rd_addr, write_data} !== {e.rd, e.data}) begin
        n_bad++;
        $display("FAIL rd0_cycle%0d got we=%0b rd=%0d data=%h required we=0 rd=%0d data=%h",
                 i, regWrite, rd_addr, write_data, e.rd, e.data);
      end
      drive_idle();
    end
    chk_addr = 5'd0;
    #1;
    n_total++;
    if (mem_ready !== 1'b1 || chk_pending !== 1'b0 || mq.size() != 0) begin
      n_bad++;
      $display("FAIL rd0_drained got ready=%0b pending=%0b required ready=1 pending=0",
               mem_ready, chk_pending);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic exp_pend;
    for (int i = 0; i < 300; i++) begin
      alu_valid   = ($urandom_range(0, 99) < 45);
      alu_rd      = 5'($urandom_range(0, 31));
      alu_result  = $urandom;
      mem_valid   = ($urandom_range(0, 99) < 55);
      mem_rd      = 5'($urandom_range(0, 7));
      mem_data    = $urandom;
      mem_funct3  = 3'($urandom_range(0, 7));
      mem_addr_lo = 2'($urandom_range(0, 3));
      chk_addr    = 5'($urandom_range(0, 7));
      #1;
      exp_pend = ref_pending(chk_addr);
      n_total++;
      if (mem_ready !== (mq.size() < DEPTH) || chk_pending !== exp_pend) begin
        n_bad++;
        $display("FAIL rand_comb%0d got ready=%0b pending=%0b required ready=%0b pending=%0b",
                 i, mem_ready, chk_pending, (mq.size() < DEPTH), exp_pend);
      end
      step();
      e = sbq.pop_front();
      n_total++;
      if ({regWrite, rd_addr, write_data, alu_stall} !== {e.we, e.rd, e.data, e.stall}) begin
        n_bad++;
        $display("FAIL rand_out%0d got we=%0b rd=%0d data=%h stall=%0b required we=%0b rd=%0d data=%h stall=%0b",
                 i, regWrite, rd_addr, write_data, alu_stall, e.we, e.rd, e.data, e.stall);
      end
    end
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      step();
      e = sbq.pop_front();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    drive_idle();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_result = 32'h77;
    mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h88; mem_funct3 = 3'b010;
    step();
    e = sbq.pop_front();
    n_total++;
    if ({regWrite, rd_addr, write_data} !== {1'b1, 5'd7, 32'h77}) begin
      n_bad++;
      $display("FAIL pre_reset got we=%0b rd=%0d data=%h required we=1 rd=7 data=77",
               regWrite, rd_addr, write_data);
    end
    drive_idle();
    chk_addr = 5'd8;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_total++;
    if ({regWrite, rd_addr, write_data, alu_stall} !== 39'd0 || mem_ready !== 1'b1 ||
        chk_pending !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset got we=%0b rd=%0d data=%h stall=%0b ready=%0b pending=%0b required zeros ready=1",
               regWrite, rd_addr, write_data, alu_stall, mem_ready, chk_pending);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      e = sbq.pop_front();
      n_total++;
      if ({regWrite, rd_addr, write_data} !== {e.we, e.rd, e.data} || regWrite !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset%0d got we=%0b rd=%0d data=%h required we=0 rd=0 data=0",
                 i, regWrite, rd_addr, write_data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_bad = 0;
    test_reset();
    test_alu_single();
    test_load_extract();
    test_alu_and_load();
    test_starve();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
